mem_stage_dual: RTL
===================

Name: mem_stage_dual

Overview:
- Dual-issue memory stage; sits directly upstream of the write-back stage and owns the EX→MEM pipeline register.
- Captures two lines from EX and waits for the data-SRAM response of a line1 load/store.
- Aligns and sign/zero-extends load data, then hands both lines to WB under valid/allowin handshake.
- Honours the WB exception flush, including discarding a stale SRAM response.

Parameters:
- DATA_W, 32, data/result width
- PC_W, 32, PC width
- RA_W, 5, register-file address width

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- line1_pre_to_now_valid_i / line2_pre_to_now_valid_i  in  1 each  EX lines valid
- now_allowin_o  out  1  stage can accept new pair
- next_allowin_i  in  1  WB allowin
- line1_now_to_next_valid_o / line2_now_to_next_valid_o  out  1 each  valid to WB
- excep_flush_i  in  1  flush from WB
- lineN_pc_i (N=1,2)  in  PC_W  PC
- lineN_we_i  in  1  reg write enable
- lineN_dest_i  in  RA_W  dest reg
- lineN_result_i  in  DATA_W  ALU result / address
- line1_mem_en_i  in  1  line1 issued a data-SRAM request in EX; memory ops only on line1
- line1_mem_wr_i  in  1  request is a store
- line1_ld_type_i  in  3  000 W, 001 B, 010 H, 101 BU, 110 HU
- data_sram_data_ok_i  in  1  response beat
- data_sram_rdata_i  in  DATA_W  load data
- lineN_pc_o, lineN_we_o, lineN_dest_o, lineN_wdata_o  out  to WB
- lineN_fwd_we_o, lineN_fwd_dest_o, lineN_fwd_data_o, lineN_fwd_ready_o  out  forwarding to ID (optional feature)

Behaviour:
- Reset (rst_n=0 at posedge): both line valids=0, FSM=IDLE, buffer cleared. Every registered output is 0.
- Capture: on a posedge with now_allowin_o=1, each line's valid reg loads the corresponding pre valid and its payload loads.
- Payload is loaded only when some pre valid=1.
- now_allowin_o = (!v1 && !v2) || (ready_go && next_allowin_i), forced to 0 in DROP.
- ready_go = !(v1 && line1_mem_en) || state==HOLD || (state==WAIT && data_ok).
- lineN_now_to_next_valid_o = vN && ready_go && !excep_flush_i.
- A pair moves together; line2 never advances without line1.
- FSM states:
  - IDLE: no pending response. Entering with v1 && mem_en → WAIT.
  - WAIT, data_ok=1 && next_allowin=1: data passes combinationally to WB (0 extra cycles). Go to IDLE, or stay in WAIT if a new mem op is captured the same edge.
  - WAIT, data_ok=1 && next_allowin=0: rdata latched into buffer → HOLD.
  - WAIT, excep_flush_i=1 && data_ok=0: → DROP.
  - WAIT, excep_flush_i=1 && data_ok=1: response consumed, valids cleared → IDLE.
  - HOLD: output uses the buffer. On next_allowin → IDLE/WAIT as above. Flush → IDLE.
  - DROP: stage empty, allowin=0. The next data_ok is discarded → IDLE.
- Flush: excep_flush_i clears v1 and v2 at the next edge, overriding a same-cycle capture.
- Load alignment uses result[1:0]:
  - B/BU: byte select [8k+7:8k], k=addr[1:0].
  - H/HU: half select by addr[1]; addr[0] ignored.
  - W: unmodified.
  - Signed types sign-extend; U types zero-extend.
- wdata = aligned load data for line1 load; otherwise result.
- Stores: wait for data_ok identically; wdata = result.
- data_ok while IDLE (spurious): ignored.

Optional Feature:
- MEM_FORWARD_EN defined:
  - lineN_fwd_we_o = vN && lineN_we.
  - fwd_dest/data mirror WB outputs.
  - fwd_ready_o = 0 only for a line1 load not yet ready_go.
- MEM_FORWARD_EN undefined: all fwd outputs tied 0; no added logic.

Test Plan:
- Reset mid-WAIT: rst_n=0 one edge → valids 0, FSM IDLE, now_allowin_o=1. A following data_ok is ignored.
- ALU pair, next_allowin=1: both valids in with results 0x11/0x22 → next cycle both to_next valids=1, wdata 0x11/0x22.
- LB at addr ...3, rdata 0x80FF_0000:
  - data_ok two cycles after capture → wdata 0xFFFF_FF80, valid only in the data_ok cycle.
  - Same access as LBU → 0x0000_0080.
- Backpressure: LH addr ...2, data_ok with next_allowin=0 for 3 cycles, rdata changes afterward → HOLD. Output 0xFFFF_8xxx from buffer persists; released when next_allowin=1.
- Flush in WAIT: excep_flush_i=1 before data_ok → DROP, now_allowin_o=0 until data_ok. That data never reaches WB; then allowin=1.
- Flush racing capture: pre valids=1, now_allowin_o=1, excep_flush_i=1 same edge → valids remain 0.

Source files
------------

// File: rtl/mem_stage_dual.sv
// Dual-issue MEM stage: holds the EX->MEM pair, waits on the line1 data-SRAM response, aligns loads for WB.
// Define MEM_FORWARD_EN to drive the ID forwarding outputs; otherwise they are tied to zero.
module mem_stage_dual #(
    parameter int DATA_W = 32,
    parameter int PC_W   = 32,
    parameter int RA_W   = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              line1_pre_to_now_valid_i,
    input  logic              line2_pre_to_now_valid_i,
    output logic              now_allowin_o,
    input  logic              next_allowin_i,
    output logic              line1_now_to_next_valid_o,
    output logic              line2_now_to_next_valid_o,
    input  logic              excep_flush_i,
    input  logic [PC_W-1:0]   line1_pc_i,
    input  logic [PC_W-1:0]   line2_pc_i,
    input  logic              line1_we_i,
    input  logic              line2_we_i,
    input  logic [RA_W-1:0]   line1_dest_i,
    input  logic [RA_W-1:0]   line2_dest_i,
    input  logic [DATA_W-1:0] line1_result_i,
    input  logic [DATA_W-1:0] line2_result_i,
    input  logic              line1_mem_en_i,
    input  logic              line1_mem_wr_i,
    input  logic [2:0]        line1_ld_type_i,
    input  logic              data_sram_data_ok_i,
    input  logic [DATA_W-1:0] data_sram_rdata_i,
    output logic [PC_W-1:0]   line1_pc_o,
    output logic [PC_W-1:0]   line2_pc_o,
    output logic              line1_we_o,
    output logic              line2_we_o,
    output logic [RA_W-1:0]   line1_dest_o,
    output logic [RA_W-1:0]   line2_dest_o,
    output logic [DATA_W-1:0] line1_wdata_o,
    output logic [DATA_W-1:0] line2_wdata_o,
    output logic              line1_fwd_we_o,
    output logic              line2_fwd_we_o,
    output logic [RA_W-1:0]   line1_fwd_dest_o,
    output logic [RA_W-1:0]   line2_fwd_dest_o,
    output logic [DATA_W-1:0] line1_fwd_data_o,
    output logic [DATA_W-1:0] line2_fwd_data_o,
    output logic              line1_fwd_ready_o,
    output logic              line2_fwd_ready_o
);
    // state | meaning
    // IDLE  | no SRAM response outstanding
    // WAIT  | line1 mem op captured, waiting for data_ok
    // HOLD  | response latched in rbuf, WB not yet accepting
    // DROP  | flushed while waiting; next data_ok is discarded
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD, S_DROP} state_t;

    state_t              state;
    logic                v1, v2;
    logic [PC_W-1:0]     pc1, pc2;
    logic                we1, we2;
    logic [RA_W-1:0]     dest1, dest2;
    logic [DATA_W-1:0]   res1, res2;
    logic                mem_en1, mem_wr1;
    logic [2:0]          ld_type1;
    logic [DATA_W-1:0]   rbuf;
    logic                ready_go;
    logic                capture_mem;
    logic [DATA_W-1:0]   ld_src;
    logic [7:0]          ld_byte;
    logic [15:0]         ld_half;
    logic [DATA_W-1:0]   ld_data;

    assign ready_go = !(v1 && mem_en1) || (state == S_HOLD) ||
                      (state == S_WAIT && data_sram_data_ok_i);
    assign now_allowin_o = (state != S_DROP) && ((!v1 && !v2) || (ready_go && next_allowin_i));
    assign capture_mem = now_allowin_o && line1_pre_to_now_valid_i && line1_mem_en_i && !excep_flush_i;

    assign line1_now_to_next_valid_o = v1 && ready_go && !excep_flush_i;
    assign line2_now_to_next_valid_o = v2 && ready_go && !excep_flush_i;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            v1       <= 1'b0;
            v2       <= 1'b0;
            pc1      <= '0;
            pc2      <= '0;
            we1      <= 1'b0;
            we2      <= 1'b0;
            dest1    <= '0;
            dest2    <= '0;
            res1     <= '0;
            res2     <= '0;
            mem_en1  <= 1'b0;
            mem_wr1  <= 1'b0;
            ld_type1 <= '0;
            rbuf     <= '0;
        end else begin
            if (excep_flush_i) begin
                v1 <= 1'b0;
                v2 <= 1'b0;
            end else if (now_allowin_o) begin
                v1 <= line1_pre_to_now_valid_i;
                v2 <= line2_pre_to_now_valid_i;
            end
            if (now_allowin_o && (line1_pre_to_now_valid_i || line2_pre_to_now_valid_i)) begin
                pc1      <= line1_pc_i;
                pc2      <= line2_pc_i;
                we1      <= line1_we_i;
                we2      <= line2_we_i;
                dest1    <= line1_dest_i;
                dest2    <= line2_dest_i;
                res1     <= line1_result_i;
                res2     <= line2_result_i;
                mem_en1  <= line1_mem_en_i;
                mem_wr1  <= line1_mem_wr_i;
                ld_type1 <= line1_ld_type_i;
            end
            case (state)
                S_IDLE: if (capture_mem) state <= S_WAIT;
                S_WAIT: begin
                    if (excep_flush_i) begin
                        state <= data_sram_data_ok_i ? S_IDLE : S_DROP;
                    end else if (data_sram_data_ok_i) begin
                        if (next_allowin_i) begin
                            state <= capture_mem ? S_WAIT : S_IDLE;
                        end else begin
                            rbuf  <= data_sram_rdata_i;
                            state <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (excep_flush_i)       state <= S_IDLE;
                    else if (next_allowin_i) state <= capture_mem ? S_WAIT : S_IDLE;
                end
                S_DROP: if (data_sram_data_ok_i) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Load data comes straight from the SRAM in WAIT, from the latched copy in HOLD.
    always_comb begin
        ld_src  = (state == S_HOLD) ? rbuf : data_sram_rdata_i;
        ld_byte = ld_src[{res1[1:0], 3'b000} +: 8];
        ld_half = res1[1] ? ld_src[31:16] : ld_src[15:0];
        case (ld_type1)
            3'b001:  ld_data = {{(DATA_W-8){ld_byte[7]}}, ld_byte};
            3'b101:  ld_data = {{(DATA_W-8){1'b0}}, ld_byte};
            3'b010:  ld_data = {{(DATA_W-16){ld_half[15]}}, ld_half};
            3'b110:  ld_data = {{(DATA_W-16){1'b0}}, ld_half};
            default: ld_data = ld_src;
        endcase
    end

    assign line1_pc_o    = pc1;
    assign line2_pc_o    = pc2;
    assign line1_we_o    = we1;
    assign line2_we_o    = we2;
    assign line1_dest_o  = dest1;
    assign line2_dest_o  = dest2;
    assign line1_wdata_o = (mem_en1 && !mem_wr1) ? ld_data : res1;
    assign line2_wdata_o = res2;

`ifdef MEM_FORWARD_EN
    assign line1_fwd_we_o    = v1 && we1;
    assign line2_fwd_we_o    = v2 && we2;
    assign line1_fwd_dest_o  = dest1;
    assign line2_fwd_dest_o  = dest2;
    assign line1_fwd_data_o  = line1_wdata_o;
    assign line2_fwd_data_o  = line2_wdata_o;
    assign line1_fwd_ready_o = !(v1 && mem_en1 && !mem_wr1 && !ready_go);
    assign line2_fwd_ready_o = 1'b1;
`else
    assign line1_fwd_we_o    = 1'b0;
    assign line2_fwd_we_o    = 1'b0;
    assign line1_fwd_dest_o  = '0;
    assign line2_fwd_dest_o  = '0;
    assign line1_fwd_data_o  = '0;
    assign line2_fwd_data_o  = '0;
    assign line1_fwd_ready_o = 1'b0;
    assign line2_fwd_ready_o = 1'b0;
`endif
endmodule
